inst_fetch_if: RTL

- Instruction-side bus bridge between the CPU core's ROM port (rom_addr_o, rom_ce_o, rom_data_i) and a variable-latency instruction memory with a req/ack handshake.
- Holds a one-entry fetch buffer tagged with its address.
- Raises a stall request to the core's pipeline control until the requested word is present.
- Sits directly downstream of the core's fetch address output and upstream of its instruction input.

---
 rtl/inst_fetch_if_pkg.sv | 23 ++
 rtl/inst_fetch_if_fetch_buf.sv | 41 ++++
 rtl/inst_fetch_if.sv | 139 +++++++++++++
 3 files changed

// File: rtl/inst_fetch_if_pkg.sv
// rtl/inst_fetch_if_pkg.sv - shared bus widths, constants and FSM encoding for inst_fetch_if
package inst_fetch_if_pkg;

    localparam int INST_ADDR_BUS_W = 32;
    localparam int REG_BUS_W       = 32;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [31:0] IFI_NOP_INST = ZERO_WORD;

    localparam int IFI_TIMEOUT_DEF = 255;
    localparam int IFI_CNT_W       = 8;

    typedef enum logic [1:0] {
        IFI_IDLE  = 2'b00,
        IFI_REQ   = 2'b01,
        IFI_DRAIN = 2'b10
    } ifi_state_e;

    function automatic logic [IFI_CNT_W-1:0] sat_inc8(input logic [IFI_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/inst_fetch_if_fetch_buf.sv
// rtl/inst_fetch_if_fetch_buf.sv - one-entry address-tagged instruction buffer with hit compare
module fetch_buf #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    output logic              hit,
    output logic [DATA_W-1:0] inst
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Flush always beats a fill so a redirected word can never be consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= NOP_INST;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr;
            data_q  <= fill_data;
        end
    end

    assign hit  = ce & valid_q & (addr_q == addr);
    assign inst = hit ? data_q : NOP_INST;

endmodule

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction-side bridge from core ROM port to req/ack memory; optional INST_FETCH_STATS_EN
module inst_fetch_if
    import inst_fetch_if_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_BUS_W,
    parameter int                DATA_W   = REG_BUS_W,
    parameter int                TIMEOUT  = IFI_TIMEOUT_DEF,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(IFI_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] cpu_inst_o,
    output logic              stallreq_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              timeout_o
`ifdef INST_FETCH_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam logic [IFI_CNT_W-1:0] TIMEOUT_LAST = IFI_CNT_W'(TIMEOUT - 1);

    ifi_state_e           state_q, state_d;
    logic                 req_q, req_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [IFI_CNT_W-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 fill_en;
    logic [DATA_W-1:0]    fill_data;
    logic                 hit;

    fetch_buf #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .ce        (cpu_ce_i),
        .addr      (cpu_addr_i),
        .flush     (flush_i),
        .fill_en   (fill_en),
        .fill_addr (addr_q),
        .fill_data (fill_data),
        .hit       (hit),
        .inst      (cpu_inst_o)
    );

    assign stallreq_o = cpu_ce_i & ~hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IFI_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        fill_en   = 1'b0;
        fill_data = mem_rdata_i;
        case (state_q)
            IFI_IDLE: begin
                if (stallreq_o && !flush_i) begin
                    state_d = IFI_REQ;
                    req_d   = 1'b1;
                    addr_d  = cpu_addr_i;
                    cnt_d   = '0;
                end
            end
            IFI_REQ, IFI_DRAIN: begin
                // Ack and timeout both end the handshake; only an unflushed REQ loads the buffer.
                if (mem_ack_i || cnt_q == TIMEOUT_LAST) begin
                    state_d = IFI_IDLE;
                    req_d   = 1'b0;
                    fill_en = (state_q == IFI_REQ) && !flush_i;
                    if (!mem_ack_i) begin
                        timeout_d = 1'b1;
                        fill_data = NOP_INST;
                    end
                end else begin
                    cnt_d = sat_inc8(cnt_q);
                    if (state_q == IFI_REQ && flush_i)
                        state_d = IFI_DRAIN;
                end
            end
            default: begin
                state_d = IFI_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign mem_req_o  = req_q;
    assign mem_addr_o = addr_q;
    assign timeout_o  = timeout_q;

`ifdef INST_FETCH_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (stallreq_o && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (state_q == IFI_IDLE && state_d == IFI_REQ && !(&miss_cnt_q))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
`endif

endmodule
